// File: rtl/ball_pkg.sv
// ball_pkg: FSM state encoding and default playfield geometry
// shared by the ball_engine slice.
package ball_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int SCREEN_W_D  = 640;
  localparam int SCREEN_H_D  = 480;
  localparam int BALL_SIZE_D = 16;

endpackage

// File: rtl/ball_tick_gen.sv
// ball_tick_gen: movement tick divider, counts 0..TICK_DIV-1 while
// enabled, holds while disabled, clears on i_clr.
module ball_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ball_engine.sv
// ball_engine: bouncing ball with wall clamping and bar collision.
// Define BALL_SPEEDUP_EN to step speeds up every SPEEDUP_EVERY bounces.
module ball_engine
  import ball_pkg::*;
#(
  parameter int SCREEN_W      = SCREEN_W_D,
  parameter int SCREEN_H      = SCREEN_H_D,
  parameter int BALL_SIZE     = BALL_SIZE_D,
  parameter int TICK_DIV      = 50000,
  parameter int SPEED_W       = 4,
  parameter int INIT_X        = 240,
  parameter int INIT_Y        = 10,
  parameter int INIT_SPEED    = 3,
  parameter int MAX_SPEED     = 8,
  parameter int SPEEDUP_EVERY = 4
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic [9:0]         bar_leftLimit,
  input  logic [9:0]         bar_rightLimit,
  input  logic [9:0]         bar_topLimit,
  input  logic [9:0]         bar_bottomLimit,
  output logic [9:0]         ball_leftLimit,
  output logic [9:0]         ball_rightLimit,
  output logic [9:0]         ball_topLimit,
  output logic [9:0]         ball_bottomLimit,
  output logic [SPEED_W-1:0] ball_x_speed,
  output logic [SPEED_W-1:0] ball_y_speed,
  output logic               ball_x_dir,
  output logic               ball_y_dir,
  output logic [7:0]         bounce_count,
  output logic               game_over,
  output logic [1:0]         state
);

  localparam logic signed [10:0] L_ZERO = 11'sd0;
  localparam logic signed [10:0] L_XMAX = 11'(SCREEN_W - 1);
  localparam logic signed [10:0] L_YMAX = 11'(SCREEN_H - 1);
  localparam logic [10:0] L_SZW  = 11'(BALL_SIZE - 1);
  localparam logic [9:0]  L_SZ   = 10'(BALL_SIZE - 1);
  localparam logic [9:0]  L_XCLP = 10'(SCREEN_W - BALL_SIZE);
  localparam logic [9:0]  L_YCLP = 10'(SCREEN_H - BALL_SIZE);

  state_t r_state;
  state_t w_state_nxt;

  logic [9:0] r_left;
  logic [9:0] r_top;
  logic       r_xdir;
  logic       r_ydir;
  logic [7:0] r_bcnt;
  logic       r_go;

  logic [SPEED_W-1:0] w_spd;
  logic               w_tick;
  logic               w_en;
  logic               w_clr;
  logic               w_rearm;
  logic               w_cnt_b;

  logic signed [10:0] w_nl;
  logic signed [10:0] w_nt;
  logic signed [10:0] w_nr;
  logic signed [10:0] w_nb;
  logic [9:0] w_cl;
  logic [9:0] w_ct;
  logic [9:0] w_cr;
  logic [9:0] w_cb;
  logic       w_xd;
  logic       w_yd;
  logic       w_bx;
  logic       w_by;
  logic       w_hit;

  assign w_en    = (r_state == ST_RUN) && !pause;
  assign w_clr   = (r_state == ST_IDLE) || (r_state == ST_OVER);
  assign w_rearm = (r_state == ST_OVER) && start;
  assign w_cnt_b = w_tick && !w_hit && (w_bx || w_by);

  ball_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .i_clk  (CLOCK_50),
    .i_rst_n(reset),
    .i_en   (w_en),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  // Candidate move, then clamp to the wall so the box never overshoots
  always_comb begin
    w_nl = r_xdir ? 11'(r_left) + 11'(w_spd)
                  : 11'(r_left) - 11'(w_spd);
    w_nt = r_ydir ? 11'(r_top) + 11'(w_spd)
                  : 11'(r_top) - 11'(w_spd);
    w_nr = w_nl + L_SZW;
    w_nb = w_nt + L_SZW;
    w_cl = w_nl[9:0];
    w_xd = r_xdir;
    w_bx = 1'b0;
    if (w_nl <= L_ZERO) begin
      w_cl = '0;
      w_xd = 1'b1;
      w_bx = 1'b1;
    end else if (w_nr >= L_XMAX) begin
      w_cl = L_XCLP;
      w_xd = 1'b0;
      w_bx = 1'b1;
    end
    w_ct = w_nt[9:0];
    w_yd = r_ydir;
    w_by = 1'b0;
    if (w_nt <= L_ZERO) begin
      w_ct = '0;
      w_yd = 1'b1;
      w_by = 1'b1;
    end else if (w_nb >= L_YMAX) begin
      w_ct = L_YCLP;
      w_yd = 1'b0;
      w_by = 1'b1;
    end
    w_cr  = w_cl + L_SZ;
    w_cb  = w_ct + L_SZ;
    w_hit = (w_cl <= bar_rightLimit) && (w_cr >= bar_leftLimit) &&
            (w_ct <= bar_bottomLimit) && (w_cb >= bar_topLimit);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_tick && w_hit) w_state_nxt = ST_OVER;
        else if (pause)      w_state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (!pause) w_state_nxt = ST_RUN;
      end
      ST_OVER: begin
        if (start) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_left <= 10'(INIT_X);
      r_top  <= 10'(INIT_Y);
      r_xdir <= 1'b1;
      r_ydir <= 1'b1;
      r_bcnt <= '0;
      r_go   <= 1'b0;
    end else if (w_rearm) begin
      r_left <= 10'(INIT_X);
      r_top  <= 10'(INIT_Y);
      r_xdir <= 1'b1;
      r_ydir <= 1'b1;
      r_bcnt <= '0;
      r_go   <= 1'b0;
    end else if (w_tick) begin
      r_left <= w_cl;
      r_top  <= w_ct;
      r_xdir <= w_xd;
      r_ydir <= w_yd;
      if (w_hit) begin
        r_go <= 1'b1;
      end else if (w_cnt_b && (r_bcnt != 8'hFF)) begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

`ifdef BALL_SPEEDUP_EN
  logic [SPEED_W-1:0] r_spd;
  logic [7:0]         r_sp_cnt;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_spd    <= SPEED_W'(INIT_SPEED);
      r_sp_cnt <= '0;
    end else if (w_rearm) begin
      r_spd    <= SPEED_W'(INIT_SPEED);
      r_sp_cnt <= '0;
    end else if (w_cnt_b) begin
      if (r_sp_cnt == 8'(SPEEDUP_EVERY - 1)) begin
        r_sp_cnt <= '0;
        if (r_spd < SPEED_W'(MAX_SPEED)) r_spd <= r_spd + 1'b1;
      end else begin
        r_sp_cnt <= r_sp_cnt + 1'b1;
      end
    end
  end

  assign w_spd = r_spd;
`else
  assign w_spd = (INIT_SPEED > MAX_SPEED) ? SPEED_W'(MAX_SPEED)
                                          : SPEED_W'(INIT_SPEED);
`endif

  assign ball_leftLimit   = r_left;
  assign ball_rightLimit  = r_left + L_SZ;
  assign ball_topLimit    = r_top;
  assign ball_bottomLimit = r_top + L_SZ;
  assign ball_x_speed     = w_spd;
  assign ball_y_speed     = w_spd;
  assign ball_x_dir       = r_xdir;
  assign ball_y_dir       = r_ydir;
  assign bounce_count     = r_bcnt;
  assign game_over        = r_go;
  assign state            = r_state;

endmodule

// File: doc/ball_engine.md
BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 Parameter SCREEN_W, default 640: playfield width in pixels.
REQ-002 Parameter SCREEN_H, default 480: playfield height in pixels.
REQ-003 Parameter BALL_SIZE, default 16: ball side length in pixels.
REQ-004 Parameter TICK_DIV, default 50000: CLOCK_50 cycles per movement tick (1 kHz at 50 MHz).
REQ-005 Parameter SPEED_W, default 4: width of the speed fields.
REQ-006 Parameter INIT_X / INIT_Y / INIT_SPEED, defaults 240 / 10 / 3: start left edge, start top edge, start speed.
REQ-007 Parameter MAX_SPEED / SPEEDUP_EVERY, defaults 8 / 4: speed ceiling; wall bounces per speed step.
REQ-008 CLOCK_50  in  1: the single clock; reset  in  1: asynchronous, active-low reset.
REQ-009 start  in  1: single-cycle pulse; launches the ball from IDLE or re-arms from OVER.
REQ-010 pause  in  1: level; freezes motion while high.
REQ-011 bar_leftLimit, bar_rightLimit, bar_topLimit, bar_bottomLimit  in  10 each: obstacle box, inclusive edges.
REQ-012 ball_leftLimit, ball_rightLimit, ball_topLimit, ball_bottomLimit  out  10 each: registered ball box, inclusive edges.
REQ-013 ball_x_speed, ball_y_speed  out  SPEED_W: current speeds; ball_x_dir, ball_y_dir  out  1: 1 = right/down.
REQ-014 bounce_count  out  8: wall bounces since launch; game_over  out  1: registered; state  out  2: FSM state.

Function
REQ-015 FSM states SHALL be IDLE=0, RUN=1, PAUSE=2, OVER=3.
REQ-016 IDLE: ball held at its initial position; start -> RUN on the next edge.
REQ-017 RUN: pause=1 -> PAUSE; PAUSE: pause=0 -> RUN; all motion state frozen in PAUSE.
REQ-018 In RUN, the tick counter counts 0..TICK_DIV-1 and moves the ball on the edge where it wraps; the counter holds in PAUSE and clears in IDLE/OVER.
REQ-019 Tick move: next_left = left ± x_speed and next_top = top ± y_speed, computed at 11 bits signed; right = left+BALL_SIZE-1 and bottom = top+BALL_SIZE-1 at all times.
REQ-020 If next_left <= 0: left := 0 and x_dir := 1; if next right >= SCREEN_W-1: right := SCREEN_W-1 and x_dir := 0 (clamp, no overshoot).
REQ-021 The Y axis SHALL follow REQ-020 using 0 and SCREEN_H-1.
REQ-022 A tick with a bounce on either axis, or on both, SHALL increment bounce_count by exactly 1 (saturates at 255).
REQ-023 Collision: if the post-clamp box overlaps the bar box on both axes (inclusive), the same edge SHALL commit the position, set game_over := 1 and enter OVER; collision takes priority over the bounce count.
REQ-024 OVER: all outputs held; start -> IDLE with game_over := 0, initial position, speeds, directions (1,1) and bounce_count := 0.
REQ-025 start in RUN or PAUSE SHALL be ignored; pause in IDLE or OVER SHALL be ignored.
REQ-026 A start pulse and a tick on the same edge in OVER or IDLE SHALL take only the start transition.

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE, left=INIT_X, top=INIT_Y, speeds=INIT_SPEED, dirs=1, bounce_count=0, game_over=0 and the tick counter to 0, including mid-move.

Configuration
REQ-028 With BALL_SPEEDUP_EN defined, every SPEEDUP_EVERY-th counted bounce SHALL increment both speeds by 1, saturating at MAX_SPEED.
REQ-029 Without BALL_SPEEDUP_EN, speeds SHALL stay at INIT_SPEED, and bounce_count still counts.

Structure
REQ-030 Package ball_pkg SHALL hold the FSM state encoding, the default screen dimensions and the default BALL_SIZE.
REQ-031 The tick generator SHALL be sub-module ball_tick_gen (inputs: clock, reset, enable, clear; output: a one-cycle tick).

Verification (TICK_DIV=4, INIT_SPEED=3, bar far away unless stated)
REQ-032 Reset, then start -> state 0 then 1; after 4 cycles left=243, top=13.
REQ-033 Ball at left=623 moving right with x_speed=3 -> tick gives right=639, left=624, x_dir=0, bounce_count+1.
REQ-034 Ball at top=2 with y_dir=0 in a corner, also bouncing on X -> top=0, both dirs flip, bounce_count +1 only.
REQ-035 Bar at 300..399 x 200..219, ball moving into it -> game_over=1 and state=3 on the overlapping tick; start -> state 0, game_over=0.
REQ-036 pause held high for 10 cycles mid-count -> position frozen; motion resumes with the remaining count.
REQ-037 With BALL_SPEEDUP_EN, 4 bounces -> speeds 4; after speeds reach 8, further bounces -> speeds stay 8; reset low mid-run -> immediate IDLE with initial values.
